rr_arb_ctrl: RTL and testbench
==============================

RR_ARB_CTRL -- requirements
Module: rr_arb_ctrl

Interface
REQ-001 Parameter N, default 4: number of target (requester) ports, legal range 2..16.
REQ-002 Parameter SW, default $clog2(N): width of sel.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 t_req  input  N  per-target request (valid); bit k belongs to target k.
REQ-006 t_last  input  N  per-target end-of-packet marker, qualified by t_req[k].
REQ-007 t_ack  output  N  per-target acknowledge (ready); at most one bit set.
REQ-008 i_req  output  1  request to the shared downstream initiator (EB1.5 buffer input).
REQ-009 i_ack  input  1  acknowledge from the downstream initiator.
REQ-010 i_last  output  1  t_last of the granted target, forwarded.
REQ-011 gnt  output  N  registered one-hot grant; all-zero when idle.
REQ-012 sel  output  SW  registered binary index of the granted target, steering the shared datapath mux.

Function
REQ-013 Transfer on target k SHALL occur in any cycle with t_req[k] & t_ack[k]; downstream transfer in any cycle with i_req & i_ack.
REQ-014 States SHALL be IDLE (gnt==0) and GRANT (gnt one-hot).
REQ-015 i_req SHALL equal |(t_req & gnt); i_last SHALL equal |(t_last & t_req & gnt); t_ack SHALL equal gnt masked by i_ack; all combinational, zero latency.
REQ-016 IDLE: when t_req!=0, the next edge SHALL load the round-robin winner into gnt/sel and enter GRANT; arbitration latency exactly 1 cycle from first request to i_req.
REQ-017 Round-robin winner SHALL be the first set bit of t_req scanning upward from index ptr, wrapping from N-1 to 0.
REQ-018 ptr SHALL reset to 0 and, on each grant release, load (sel+1) mod N.
REQ-019 Release condition (macro undefined): downstream transfer in GRANT.
REQ-020 On release, the same edge SHALL load the next winner computed with the updated ptr over the current t_req excluding the released target's bit; if none, the released target itself if still requesting; else enter IDLE. No bubble between back-to-back grants.
REQ-021 In GRANT with granted t_req low and no transfer, grant SHALL be dropped at the next edge (IDLE, ptr unchanged), macro undefined only.
REQ-022 Single requester SHALL sustain one transfer per cycle after the initial 1-cycle arbitration.
REQ-023 gnt SHALL never change in a cycle with i_req & !i_ack (held while stalled).

Reset
REQ-024 Reset asserted SHALL force, asynchronously: gnt=0, sel=0, ptr=0, state IDLE, hence t_ack=0, i_req=0, i_last=0.
REQ-025 Reset asserted mid-transfer SHALL abandon the grant; after deassertion arbitration restarts from ptr=0 with 1-cycle latency.

Configuration
REQ-026 Macro RR_ARB_PKT_LOCK_EN defined: release condition SHALL be downstream transfer with i_last=1; grant held across intervening beats, including cycles with granted t_req low (REQ-021 disabled).
REQ-027 RR_ARB_PKT_LOCK_EN undefined: t_last SHALL only be forwarded to i_last and SHALL not affect arbitration; per-beat round-robin.

Verification
REQ-028 Reset, then t_req=4'b0101 held, i_ack=1 -> gnt 0001 on cycle 1, then 0100, 0001, 0100 alternating, one transfer per cycle.
REQ-029 t_req=4'b1111, i_ack=0 for 5 cycles then 1 -> gnt stays 0001 through stall; then grants 0010,0100,1000,0001 on successive cycles.
REQ-030 Only target 3 requests, continuous, i_ack=1 -> first i_req 1 cycle after t_req, then i_req=1 every cycle, gnt=1000 constant, sel=3.
REQ-031 LOCK_EN: target 0 sends 3-beat packet (last on beat 3) while target 1 requests -> gnt 0001 for all 3 beats, 0010 on the cycle after beat 3; without LOCK_EN grants alternate per beat.
REQ-032 Assert reset while gnt=0100 and i_req&!i_ack -> gnt=0, i_req=0 immediately (same cycle); after release with t_req=4'b0100 grant returns next cycle, ptr=0.

Source files
------------

// File: rtl/rr_arb_ctrl_if.sv
// Handshake bundle between N requesters, the round-robin arbiter and the shared downstream initiator.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface rr_arb_ctrl_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = $clog2(N)
);
    logic [N-1:0]  t_req;
    logic [N-1:0]  t_last;
    logic [N-1:0]  t_ack;
    logic          i_req;
    logic          i_ack;
    logic          i_last;
    logic [N-1:0]  gnt;
    logic [SW-1:0] sel;

    modport slave (
        input  t_req, t_last, i_ack,
        output t_ack, i_req, i_last, gnt, sel
    );

    modport master (
        output t_req, t_last, i_ack,
        input  t_ack, i_req, i_last, gnt, sel
    );
endinterface

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbiter steering N requesters onto one downstream initiator, zero-bubble grant handover.
// Define RR_ARB_PKT_LOCK_EN to hold the grant for a whole packet (release only on the last beat).
module rr_arb_ctrl #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    rr_arb_ctrl_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [N-1:0]  gnt_q;
    logic [SW-1:0] sel_q;
    logic [SW-1:0] ptr_q;

    logic          gnt_req;
    logic          xfer;
    logic          release_c;
    logic          drop_c;
    logic [SW-1:0] ptr_inc;
    logic          idle_hit;
    logic [SW-1:0] idle_idx;
    logic          rel_hit;
    logic [SW-1:0] rel_idx;

    // First set bit of req scanning upward from start, wrapping N-1 -> 0; MSB is the found flag.
    function automatic logic [SW:0] rr_pick(input logic [N-1:0] req, input logic [SW-1:0] start);
        logic          found;
        logic [SW-1:0] idx;
        int unsigned   k;
        logic [N-1:0]  sh;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(start) + i;
            if (k >= N) k = k - N;
            sh = req >> k;
            if (!found && sh[0]) begin
                found = 1'b1;
                idx   = SW'(k);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [SW-1:0] idx);
        return N'(1) << idx;
    endfunction

    always_comb begin
        gnt_req = |(bus.t_req & gnt_q);
        xfer    = gnt_req & bus.i_ack;
`ifdef RR_ARB_PKT_LOCK_EN
        release_c = xfer & (|(bus.t_last & gnt_q));
        drop_c    = 1'b0;
`else
        release_c = xfer;
        drop_c    = ~gnt_req;
`endif
        ptr_inc = (sel_q == SW'(N - 1)) ? '0 : sel_q + SW'(1);
        {idle_hit, idle_idx} = rr_pick(bus.t_req, ptr_q);
        // Handover candidate excludes the target being released.
        {rel_hit, rel_idx}   = rr_pick(bus.t_req & ~gnt_q, ptr_inc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt_q <= '0;
            sel_q <= '0;
            ptr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_hit) begin
                        state <= GRANT;
                        gnt_q <= to_onehot(idle_idx);
                        sel_q <= idle_idx;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        ptr_q <= ptr_inc;
                        // Without another requester the released target keeps the grant:
                        // it just transferred, so it is still requesting.
                        if (rel_hit) begin
                            gnt_q <= to_onehot(rel_idx);
                            sel_q <= rel_idx;
                        end
                    end else if (drop_c) begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.sel    = sel_q;
    assign bus.i_req  = gnt_req;
    assign bus.i_last = |(bus.t_last & bus.t_req & gnt_q);
    assign bus.t_ack  = gnt_q & {N{bus.i_ack}};

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Directed bench for rr_arb_ctrl (N=4): rotation, stall hold, single requester, packet/beat release, reset.
`timescale 1ns/1ps
module tb_rr_arb_ctrl;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    rr_arb_ctrl_if #(.N(N), .SW(SW)) bus ();

    rr_arb_ctrl #(.N(N), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] g, input logic ireq, input logic [3:0] tack);
        check({tag, ".gnt"},   32'(bus.gnt),   32'(g));
        check({tag, ".i_req"}, 32'(bus.i_req), 32'(ireq));
        check({tag, ".t_ack"}, 32'(bus.t_ack), 32'(tack));
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        bus.t_req  = '0;
        bus.t_last = '0;
        bus.i_ack  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] seq29 [4];
        logic [3:0] tl31  [4];
        logic [3:0] g31   [4];
        logic       il31  [4];
        logic [3:0] exp_g;
        n_checks = 0;
        n_pass   = 0;
        seq29 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        tl31  = '{4'b0010, 4'b0010, 4'b0011, 4'b0011};
`ifdef RR_ARB_PKT_LOCK_EN
        g31  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        il31 = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        g31  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        il31 = '{1'b0, 1'b1, 1'b1, 1'b1};
`endif

        // Reset state
        apply_reset();
        #1;
        chk_outs("rst", 4'b0000, 1'b0, 4'b0000);
        check("rst.sel",    32'(bus.sel),    32'd0);
        check("rst.i_last", 32'(bus.i_last), 32'd0);

        // Two requesters alternate every beat
        apply_reset();
        bus.t_req = 4'b0101;
        bus.i_ack = 1'b1;
        #1;
        chk_outs("alt.c0", 4'b0000, 1'b0, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_g = (k % 2 == 1) ? 4'b0001 : 4'b0100;
            chk_outs($sformatf("alt.c%0d", k), exp_g, 1'b1, exp_g);
        end

        // All request, 5-cycle stall, then rotation
        apply_reset();
        bus.t_req = 4'b1111;
        bus.i_ack = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_outs($sformatf("stall.c%0d", k), 4'b0001, 1'b1, 4'b0000);
        end
        step();
        bus.i_ack = 1'b1;
        #1;
        chk_outs("stall.ack", 4'b0001, 1'b1, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_outs($sformatf("rot.%0d", k), seq29[k], 1'b1, seq29[k]);
        end

        // Lone requester sustains full throughput
        apply_reset();
        bus.t_req = 4'b1000;
        bus.i_ack = 1'b1;
        #1;
        check("single.c0.i_req", 32'(bus.i_req), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_outs($sformatf("single.c%0d", k), 4'b1000, 1'b1, 4'b1000);
            check($sformatf("single.c%0d.sel", k), 32'(bus.sel), 32'd3);
        end

        // 3-beat packet on target 0 while target 1 waits
        apply_reset();
        bus.t_req  = 4'b0011;
        bus.t_last = 4'b0010;
        bus.i_ack  = 1'b1;
        #1;
        check("pkt.c0.gnt", 32'(bus.gnt), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            bus.t_last = tl31[k];
            #1;
            check($sformatf("pkt.c%0d.gnt", k + 1),    32'(bus.gnt),    32'(g31[k]));
            check($sformatf("pkt.c%0d.i_last", k + 1), 32'(bus.i_last), 32'(il31[k]));
        end

        // Granted requester withdraws without transferring
        apply_reset();
        bus.t_req = 4'b0010;
        bus.i_ack = 1'b0;
        step();
        check("drop.gnt", 32'(bus.gnt), 32'b0010);
        bus.t_req = 4'b0000;
        #1;
        check("drop.i_req", 32'(bus.i_req), 32'd0);
        step();
        bus.t_req = 4'b0110;
        #1;
`ifdef RR_ARB_PKT_LOCK_EN
        check("drop.idle", 32'(bus.gnt), 32'b0010);
`else
        check("drop.idle", 32'(bus.gnt), 32'b0000);
`endif
        step();
        check("drop.regrant", 32'(bus.gnt), 32'b0010);

        // Reset during a stalled grant
        apply_reset();
        bus.t_req = 4'b0100;
        bus.i_ack = 1'b0;
        step();
        chk_outs("mrst.pre", 4'b0100, 1'b1, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("mrst.async", 4'b0000, 1'b0, 4'b0000);
        check("mrst.async.sel", 32'(bus.sel), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("mrst.rel.gnt", 32'(bus.gnt), 32'd0);
        step();
        chk_outs("mrst.regrant", 4'b0100, 1'b1, 4'b0000);
        check("mrst.regrant.sel", 32'(bus.sel), 32'd2);

        // Pointer restarts at 0 after reset
        apply_reset();
        bus.t_req = 4'b0110;
        bus.i_ack = 1'b1;
        step();
        check("ptr0.gnt", 32'(bus.gnt), 32'b0010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
